// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor computing a - b - borrow_in, one bit per clock, LSB
// first. A start accepted in IDLE captures the operands; WIDTH clocks later
// the full difference and the final borrow appear together on diff and
// borrow_out, with a single-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   start      request, sampled only in IDLE
//   a, b       minuend / subtrahend, captured when start is accepted
//   borrow_in  initial borrow, captured when start is accepted
//   busy       high while bits are being processed
//   done       single-cycle pulse when diff/borrow_out are updated
//   diff       registered a - b - borrow_in (mod 2^WIDTH)
//   borrow_out final borrow out of the MSB
//   ovf        two's-complement overflow flag (only with SERIAL_SUB_OVF_EN)
//
// Build option:
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output and its logic.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             bq;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             bq_next;
    logic [WIDTH-1:0] a_next;

    // Full subtractor on the current bit pair. The difference bit enters the
    // MSB of a_sh as the consumed minuend bit leaves the LSB, so after WIDTH
    // shifts a_sh holds the complete result without a separate register.
    always_comb begin
        x       = a_sh[0];
        y       = b_sh[0];
        d       = x ^ y ^ bq;
        bq_next = (~x & y) | (~(x ^ y) & bq);
        a_next  = {d, a_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            bq         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bq    <= borrow_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_next;
                    b_sh <= b_sh >> 1;
                    bq   <= bq_next;
                    cnt  <= cnt + 1'b1;
                    // On the last bit x and y are the captured operand MSBs
                    // and d is the result MSB, so overflow needs no extra flops.
                    if (cnt == LAST) begin
                        diff       <= a_next;
                        borrow_out <= bq_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (x != y) && (d != x);
`endif
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
